// File: rtl/seq_mul_ctrl.sv
// Sequential shift-add multiplier (unsigned or signed), one multiplier bit per clock.
// Define MUL_EARLY_TERM_EN to end a run once the remaining multiplier bits are all zero.
`timescale 1ns/1ps
module seq_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               neg_in;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_next;
  logic [2*WIDTH-1:0] result;
  logic               finish_cond;
  logic               load;
  logic               step;
  logic               finish_now;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  assign abs_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  assign acc_sum     = mplier[0] ? (acc + mcand) : acc;
  assign mplier_next = mplier >> 1;
  assign result      = neg ? -acc_sum : acc_sum;

`ifdef MUL_EARLY_TERM_EN
  assign finish_cond = (mplier_next == '0) || (cnt == LAST_CNT);
`else
  assign finish_cond = (cnt == LAST_CNT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    finish_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (finish_cond) begin
          state_d    = IDLE;
          finish_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, abs_a};
      acc    <= '0;
      mplier <= abs_b;
      cnt    <= '0;
      neg    <= neg_in;
    end else if (step) begin
      mcand  <= mcand << 1;
      acc    <= acc_sum;
      mplier <= mplier_next;
      cnt    <= cnt + CW'(1);
    end
  end

  // Product is only touched on a completion edge, so it holds between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_d == RUN);
      done <= finish_now;
      if (finish_now) begin
        product <= result;
      end
    end
  end

endmodule

// File: doc/seq_mul_ctrl.md
# seq_mul_ctrl

Parametrised sequential shift-add multiplier with a start/busy/done handshake, replacing the fixed 32-bit reset-started multiplier. Computes an unsigned or two's-complement signed WIDTH×WIDTH product, one multiplier bit per clock. It sits beside the ALU as a multi-cycle functional unit. The result is held until the next operation completes.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH; legal range 4..64

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only while busy=0
- signed_mode  input  1  1 = operands and product are two's complement; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; product is valid from this cycle onward
- product  output  2*WIDTH  registered result; held until the next completion

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN when start=1 at a clock edge. At that edge:
  - mcand ← |a| zero-extended to 2*WIDTH.
  - mplier ← |b|.
  - acc ← 0.
  - neg ← signed_mode & (a[MSB] ^ b[MSB]).
  - cnt ← 0.
  - busy ← 1.
- Magnitude rule: |x| = -x when signed_mode=1 and x[MSB]=1, otherwise x.
  - The most negative value maps to 2^(WIDTH-1). This fits unsigned in WIDTH bits, so no overflow.
- RUN, each edge:
  - If mplier[0]=1, acc ← acc + mcand (2*WIDTH bits, carry-out discarded; it cannot occur).
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
- RUN → IDLE on the edge where the finishing condition holds (see Configuration). On that edge:
  - product ← final acc, two's-complement negated if neg=1.
  - done ← 1 and busy ← 0.
- Negating zero yields zero. A signed result is never -0 and needs no special case.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- start in the cycle where done=1 is accepted. The FSM is already in IDLE, so back-to-back operations are allowed.
- signed_mode, a and b are don't-care outside the start-accept edge.
- cnt width is $clog2(WIDTH+1).

## Timing
- Reset values: busy=0, done=0, product=0, FSM=IDLE, all internal registers 0.
- Reset asserted mid-operation aborts immediately (asynchronous). No done is issued and product returns to 0.
- Start accepted at edge k:
  - busy is high from after edge k until after edge k+L.
  - done is high for exactly the one cycle after edge k+L.
  - product updates at edge k+L.
- L (latency):
  - Default build: L = WIDTH.
  - Early-termination build: L = max(1, position of the highest set bit of |b| + 1).
- product never changes except at a completion edge or on reset.

## Configuration
- Macro MUL_EARLY_TERM_EN.
- Defined: RUN finishes on the edge where the post-update mplier equals 0, or cnt reaches WIDTH-1 (whichever comes first).
  - This is data-dependent latency. b=0 and b=1 both complete in 1 cycle.
- Undefined: RUN finishes only on the edge where cnt = WIDTH-1. Fixed latency L = WIDTH.
- Results are identical in both builds; only latency differs.

## Test plan
- WIDTH=32, unsigned, a=0x0000000F, b=0x00000003 → product=64'h2D.
  - done pulses exactly 32 cycles after start (default build), or 2 cycles after start with MUL_EARLY_TERM_EN.
- Unsigned, a=0x11111111, b=0 → product=0; b=0x7D, a=0x4E → product=64'h2616 (9750).
  - Back-to-back: the second start is issued in the done cycle of the first and is accepted.
- Signed, a=-7 (0xFFFFFFF9), b=6 → product=64'hFFFFFFFFFFFFFFD6.
  - Signed a=0x80000000, b=0x80000000 → 64'h4000000000000000.
  - Same operands unsigned → 64'h4000000000000000; unsigned a=b=0xFFFFFFFF → 64'hFFFFFFFE00000001.
- start with new operands while busy → ignored; the original product is delivered with the original latency, and exactly one done pulse occurs.
- rst asserted mid-RUN (cycle 10, asynchronously between edges) → busy, done and product go to 0 immediately. No done follows, and a fresh start afterward completes correctly.
- WIDTH=8 instance, signed, a=-128, b=-1 → product=16'h0080; unsigned a=0xFF, b=0xFF → 16'hFE01; done after 8 cycles (default build).
